// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 raster window generator with two line buffers for Sobel filtering
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [7:0]  pix_in,
    input  logic        in_sof,
    output logic        shift_en,
    output logic        pos_valid,
    output logic [11:0] a22_x,
    output logic [11:0] a22_y,
    output logic [7:0]  a11,
    output logic [7:0]  a12,
    output logic [7:0]  a13,
    output logic [7:0]  a21,
    output logic [7:0]  a22,
    output logic [7:0]  a23,
    output logic [7:0]  a31,
    output logic [7:0]  a32,
    output logic [7:0]  a33,
    output logic        frame_done
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [11:0] LAST_COL = 12'(IMG_W - 1);
    localparam logic [11:0] LAST_ROW = 12'(IMG_H - 1);

    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [11:0]   col;
    logic [11:0]   row;
    logic [11:0]   c_eff;
    logic [11:0]   r_eff;
    logic [AW-1:0] idx;
    logic [7:0]    lb0_rd;
    logic [7:0]    lb1_rd;

    // A start-of-frame pixel overrides whatever position the counters hold.
    always_comb begin
        c_eff  = in_sof ? 12'd0 : col;
        r_eff  = in_sof ? 12'd0 : row;
        idx    = c_eff[AW-1:0];
        lb0_rd = lb0[idx];
        lb1_rd = lb1[idx];
    end

    // Line buffers carry no reset; their contents are refilled before any window is flagged valid.
    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            lb1[idx] <= lb0_rd;
            lb0[idx] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_en   <= 1'b0;
            pos_valid  <= 1'b0;
            frame_done <= 1'b0;
            a22_x      <= '0;
            a22_y      <= '0;
            a11 <= '0; a12 <= '0; a13 <= '0;
            a21 <= '0; a22 <= '0; a23 <= '0;
            a31 <= '0; a32 <= '0; a33 <= '0;
            col        <= '0;
            row        <= '0;
        end else begin
            shift_en   <= pix_valid;
            frame_done <= 1'b0;
            if (pix_valid) begin
                a11 <= a12; a12 <= a13; a13 <= lb1_rd;
                a21 <= a22; a22 <= a23; a23 <= lb0_rd;
                a31 <= a32; a32 <= a33; a33 <= pix_in;
                pos_valid  <= (r_eff >= 12'd2) && (c_eff >= 12'd2);
                // Clamp so the centre position never underflows at the image edge.
                a22_x      <= (c_eff != 12'd0) ? c_eff - 12'd1 : 12'd0;
                a22_y      <= (r_eff != 12'd0) ? r_eff - 12'd1 : 12'd0;
                frame_done <= (r_eff == LAST_ROW) && (c_eff == LAST_COL);
                if (c_eff == LAST_COL) begin
                    col <= '0;
                    row <= (r_eff == LAST_ROW) ? 12'd0 : r_eff + 12'd1;
                end else begin
                    col <= c_eff + 12'd1;
                    row <= r_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench for sobel_window_gen at an 8x6 image
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_in = 8'd0;
    logic        in_sof = 1'b0;
    logic        shift_en, pos_valid, frame_done;
    logic [11:0] a22_x, a22_y;
    logic [7:0]  a11, a12, a13, a21, a22, a23, a31, a32, a33;
    logic [71:0] win;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in), .in_sof(in_sof),
        .shift_en(shift_en), .pos_valid(pos_valid), .a22_x(a22_x), .a22_y(a22_y),
        .a11(a11), .a12(a12), .a13(a13), .a21(a21), .a22(a22), .a23(a23),
        .a31(a31), .a32(a32), .a33(a33), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    assign win = {a11, a12, a13, a21, a22, a23, a31, a32, a33};

    typedef struct {bit pv; bit done; int r; int c;} exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int n_shift = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Pixel values are row*8+col, so a valid window is fully determined by its centre.
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        int v;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                v = (r - 2 + i) * 8 + (c - 2 + j);
                w[71 - 8*(3*i + j) -: 8] = 8'(v);
            end
        return w;
    endfunction

    initial begin : monitor
        logic [96:0] snap;
        exp_t e;
        snap = '0;
        forever begin
            @(negedge clk);
            if (shift_en) begin
                n_shift++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_shift_en: got 1 required 0");
                end else begin
                    e = q.pop_front();
                    check("pos_valid", 128'(pos_valid), 128'(e.pv));
                    check("frame_done", 128'(frame_done), 128'(e.done));
                    if (e.pv) begin
                        check("a22_x", 128'(a22_x), 128'(e.c - 1));
                        check("a22_y", 128'(a22_y), 128'(e.r - 1));
                        check("window", 128'(win), 128'(exp_win(e.r, e.c)));
                    end
                end
            end else if (!rst) begin
                check("hold_outputs", 128'({pos_valid, a22_x, a22_y, win}), 128'(snap));
                check("frame_done_idle", 128'(frame_done), 128'(0));
            end
            snap = {pos_valid, a22_x, a22_y, win};
        end
    end

    task automatic send(input int r, input int c, input bit sof);
        exp_t e;
        @(negedge clk);
        pix_valid = 1'b1;
        in_sof = sof;
        pix_in = 8'(r * 8 + c);
        e.pv = (r >= 2) && (c >= 2);
        e.done = (r == H - 1) && (c == W - 1);
        e.r = r;
        e.c = c;
        q.push_back(e);
        n_push++;
    endtask

    task automatic idle(input int n, input bit sof);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            in_sof = sof;
        end
    endtask

    task automatic frame(input bit sof_first, input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(r, c, sof_first && r == 0 && c == 0);
                if (gap > 0) idle(gap, 1'b1);
            end
        idle(3, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_shift_en"}, 128'(shift_en), 128'(0));
        check({tag, "_pos_valid"}, 128'(pos_valid), 128'(0));
        check({tag, "_frame_done"}, 128'(frame_done), 128'(0));
        check({tag, "_pos"}, 128'({a22_x, a22_y}), 128'(0));
        check({tag, "_window"}, 128'(win), 128'(0));
    endtask

    initial begin : driver
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b0);

        frame(1'b1, 0);
        frame(1'b1, 2);

        // Partial frame up to (3,4), then an asynchronous reset between edges.
        begin : partial
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < W; c++) begin
                    send(r, c, r == 0 && c == 0);
                    if (r == 3 && c == 4) disable partial;
                end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        in_sof = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        #2 rst = 1'b0;
        idle(2, 1'b0);
        frame(1'b1, 0);

        // Abort after four lines: the sof pixel restarts the frame at (0,0).
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                send(r, c, r == 0 && c == 0);
        frame(1'b1, 0);

        frame(1'b1, 0);
        frame(1'b0, 0);

        idle(4, 1'b0);
        check("queue_drained", 128'(q.size()), 128'(0));
        check("shift_en_count", 128'(n_shift), 128'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
